preprocess_control: RTL and testbench

Passive AXI4-Stream header-word tracker for the router output-port-lookup pipeline. It watches the 256-bit ingress stream alongside the datapath and emits single-cycle strobes marking which beat carries which header field; the destination-IP filter, MAC checker and other lookup stages latch `tdata` on these strobes. It also classifies each packet as plain IPv4 (no options) and flags runt packets. It never stalls or modifies the stream.

---
 rtl/preprocess_control.sv | 103 ++++++++++
 tb/tb_preprocess_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/preprocess_control.sv
// preprocess_control
//   Passive AXI4-Stream header-word tracker. It watches the ingress stream and
//   raises single-cycle strobes marking which beat carries which header field,
//   so that the downstream lookup stages can latch tdata on them. It also
//   classifies each packet as plain IPv4 (no options) and flags runt packets.
//   It never stalls or modifies the stream.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   tdata/tvalid/tready/tlast   monitored stream (tready as driven downstream)
//   word_MAC_HDR        beat 0 accepted (MAC DA/SA, ethertype)         [comb]
//   word_IP_DST_HI      beat 0 accepted (IP dst bytes 0-1 in [255:240]) [comb]
//   word_IP_DST_LO      beat 1 accepted (IP dst bytes 2-3 in [15:0])    [comb]
//   word_PAYLOAD        any beat with index >= 2 accepted               [comb]
//   runt_pkt            tlast accepted on beat 0                        [comb]
//   pkt_done            tlast accepted on any beat                      [comb]
//   is_ipv4             last beat 0 was IPv4 with IHL 5                 [reg]
//   is_ipv4_vld         one-cycle pulse when is_ipv4 updates            [reg]
//   word_cnt            beats accepted so far in this packet, saturating [reg]

module preprocess_control #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
  parameter int unsigned WORD_CNT_BITS       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata,
  input  logic                           tvalid,
  input  logic                           tready,
  input  logic                           tlast,
  output logic                           word_MAC_HDR,
  output logic                           word_IP_DST_HI,
  output logic                           word_IP_DST_LO,
  output logic                           word_PAYLOAD,
  output logic                           is_ipv4,
  output logic                           is_ipv4_vld,
  output logic                           runt_pkt,
  output logic                           pkt_done,
  output logic [WORD_CNT_BITS-1:0]       word_cnt
);

  typedef enum logic [1:0] {
    WORD0   = 2'd0,
    WORD1   = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [WORD_CNT_BITS-1:0] CNT_MAX = '1;

  state_t state;
  logic   beat;
  logic   hdr_is_ipv4;
  logic   unused_tdata;

  assign beat = tvalid & tready;

  // Ethertype 0x0800 in bytes 12-13, version 4 / IHL 5 in byte 14
  assign hdr_is_ipv4 = (tdata[103:96]  == 8'h08) &&
                       (tdata[111:104] == 8'h00) &&
                       (tdata[119:116] == 4'd4)  &&
                       (tdata[115:112] == 4'd5);

  // Only the header bytes above are inspected; the rest of the beat is ignored
  assign unused_tdata = ^{tdata[C_S_AXIS_DATA_WIDTH-1:120], tdata[95:0]};

  // Strobes are combinational so they line up with the tdata they mark
  assign word_MAC_HDR   = beat & (state == WORD0);
  assign word_IP_DST_HI = beat & (state == WORD0);
  assign word_IP_DST_LO = beat & (state == WORD1);
  assign word_PAYLOAD   = beat & (state == PAYLOAD);
  assign runt_pkt       = beat & tlast & (state == WORD0);
  assign pkt_done       = beat & tlast;

  // Beat-position FSM, IPv4 classifier and per-packet beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WORD0;
      word_cnt    <= '0;
      is_ipv4     <= 1'b0;
      is_ipv4_vld <= 1'b0;
    end else begin
      is_ipv4_vld <= 1'b0;
      if (beat) begin
        case (state)
          WORD0: begin
            is_ipv4     <= hdr_is_ipv4;
            is_ipv4_vld <= 1'b1;
            state       <= tlast ? WORD0 : WORD1;
          end
          WORD1:   state <= tlast ? WORD0 : PAYLOAD;
          PAYLOAD: state <= tlast ? WORD0 : PAYLOAD;
          default: state <= WORD0;
        endcase
        if (tlast) begin
          word_cnt <= '0;
        end else if (word_cnt != CNT_MAX) begin
          word_cnt <= word_cnt + WORD_CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_preprocess_control.sv
// Directed testbench for preprocess_control. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, so combinational strobes show
// the beat being presented and registered outputs show the previous beat.

module tb_preprocess_control;

  localparam int unsigned DW = 256;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          reset;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          word_MAC_HDR;
  logic          word_IP_DST_HI;
  logic          word_IP_DST_LO;
  logic          word_PAYLOAD;
  logic          is_ipv4;
  logic          is_ipv4_vld;
  logic          runt_pkt;
  logic          pkt_done;
  logic [CW-1:0] word_cnt;

  int passed = 0;
  int total  = 0;

  preprocess_control #(
    .C_S_AXIS_DATA_WIDTH(DW),
    .WORD_CNT_BITS      (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tdata         (tdata),
    .tvalid        (tvalid),
    .tready        (tready),
    .tlast         (tlast),
    .word_MAC_HDR  (word_MAC_HDR),
    .word_IP_DST_HI(word_IP_DST_HI),
    .word_IP_DST_LO(word_IP_DST_LO),
    .word_PAYLOAD  (word_PAYLOAD),
    .is_ipv4       (is_ipv4),
    .is_ipv4_vld   (is_ipv4_vld),
    .runt_pkt      (runt_pkt),
    .pkt_done      (pkt_done),
    .word_cnt      (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Present one cycle of stimulus and settle before sampling
  task automatic drive(input logic v, input logic r, input logic l, input logic [DW-1:0] d);
    @(negedge clk);
    tvalid = v;
    tready = r;
    tlast  = l;
    tdata  = d;
    #1;
  endtask

  function automatic logic [DW-1:0] beat0(input logic [15:0] et, input logic [7:0] b14);
    logic [DW-1:0] d;
    d = '0;
    d[103:96]  = et[15:8];
    d[111:104] = et[7:0];
    d[119:112] = b14;
    d[255:240] = 16'h000A;   // dst 10.0 : byte 30 = 0x0A, byte 31 = 0x00
    return d;
  endfunction

  function automatic logic [DW-1:0] beat1();
    logic [DW-1:0] d;
    d = '0;
    d[15:0] = 16'h0201;      // dst .1.2
    return d;
  endfunction

  // 3-beat packet with full strobe and classification checks
  task automatic pkt3(input string tag, input logic [15:0] et, input logic [7:0] b14,
                      input logic exp_ipv4);
    drive(1'b1, 1'b1, 1'b0, beat0(et, b14));
    chk({tag, ".b0.mac"},   32'(word_MAC_HDR),   32'd1);
    chk({tag, ".b0.dsthi"}, 32'(word_IP_DST_HI), 32'd1);
    chk({tag, ".b0.dstlo"}, 32'(word_IP_DST_LO), 32'd0);
    chk({tag, ".b0.cnt"},   32'(word_cnt),       32'd0);
    drive(1'b1, 1'b1, 1'b0, beat1());
    chk({tag, ".b1.dstlo"}, 32'(word_IP_DST_LO), 32'd1);
    chk({tag, ".b1.dsthi"}, 32'(word_IP_DST_HI), 32'd0);
    chk({tag, ".b1.ipv4"},  32'(is_ipv4),        32'(exp_ipv4));
    chk({tag, ".b1.vld"},   32'(is_ipv4_vld),    32'd1);
    chk({tag, ".b1.cnt"},   32'(word_cnt),       32'd1);
    drive(1'b1, 1'b1, 1'b1, '0);
    chk({tag, ".b2.pay"},   32'(word_PAYLOAD),   32'd1);
    chk({tag, ".b2.done"},  32'(pkt_done),       32'd1);
    chk({tag, ".b2.runt"},  32'(runt_pkt),       32'd0);
    chk({tag, ".b2.vld"},   32'(is_ipv4_vld),    32'd0);
    chk({tag, ".b2.cnt"},   32'(word_cnt),       32'd2);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk({tag, ".idle.cnt"}, 32'(word_cnt),       32'd0);
    chk({tag, ".idle.mac"}, 32'(word_MAC_HDR),   32'd0);
    chk({tag, ".idle.done"},32'(pkt_done),       32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    tvalid = 1'b0;
    tready = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;

    // Reset, with a valid beat offered while in reset
    drive(1'b1, 1'b1, 1'b0, beat0(16'h0800, 8'h45));
    drive(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("rst.cnt",  32'(word_cnt),     32'd0);
    chk("rst.ipv4", 32'(is_ipv4),      32'd0);
    chk("rst.vld",  32'(is_ipv4_vld),  32'd0);
    chk("rst.mac",  32'(word_MAC_HDR), 32'd0);
    chk("rst.done", 32'(pkt_done),     32'd0);

    // Classification: plain IPv4, IPv4 with options, IPv4 again, IPv6
    pkt3("v4",    16'h0800, 8'h45, 1'b1);
    pkt3("v4opt", 16'h0800, 8'h46, 1'b0);
    pkt3("v4b",   16'h0800, 8'h45, 1'b1);
    pkt3("v6",    16'h86DD, 8'h60, 1'b0);

    // Runt IPv4 packet, then back-to-back beat 0 of the next packet
    drive(1'b1, 1'b1, 1'b1, beat0(16'h0800, 8'h45));
    chk("runt.runt",  32'(runt_pkt),       32'd1);
    chk("runt.done",  32'(pkt_done),       32'd1);
    chk("runt.mac",   32'(word_MAC_HDR),   32'd1);
    chk("runt.dstlo", 32'(word_IP_DST_LO), 32'd0);
    drive(1'b1, 1'b1, 1'b0, beat0(16'h86DD, 8'h60));
    chk("next.mac",   32'(word_MAC_HDR),   32'd1);
    chk("next.dstlo", 32'(word_IP_DST_LO), 32'd0);
    chk("next.runt",  32'(runt_pkt),       32'd0);
    chk("next.cnt",   32'(word_cnt),       32'd0);
    chk("runt.ipv4",  32'(is_ipv4),        32'd1);
    chk("runt.vld",   32'(is_ipv4_vld),    32'd1);

    // Stall for 4 cycles between beat 0 and beat 1 with tdata wandering
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, {8{$urandom()}});
      chk("stall.dstlo", 32'(word_IP_DST_LO), 32'd0);
      chk("stall.mac",   32'(word_MAC_HDR),   32'd0);
      chk("stall.pay",   32'(word_PAYLOAD),   32'd0);
      chk("stall.done",  32'(pkt_done),       32'd0);
      chk("stall.cnt",   32'(word_cnt),       32'd1);
      chk("stall.ipv4",  32'(is_ipv4),        32'd0);
      chk("stall.vld",   32'(is_ipv4_vld),    (i == 0) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 1'b1, 1'b1, beat1());
    chk("resume.dstlo", 32'(word_IP_DST_LO), 32'd1);
    chk("resume.done",  32'(pkt_done),       32'd1);
    chk("resume.runt",  32'(runt_pkt),       32'd0);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("resume.once",  32'(word_IP_DST_LO), 32'd0);
    chk("resume.cnt",   32'(word_cnt),       32'd0);

    // Reset after beat 1 of a 5-beat packet abandons it
    drive(1'b1, 1'b1, 1'b0, beat0(16'h0800, 8'h45));
    drive(1'b1, 1'b1, 1'b0, beat1());
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("midrst.done", 32'(pkt_done), 32'd0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, beat0(16'h0800, 8'h45));
    chk("midrst.mac",   32'(word_MAC_HDR),   32'd1);
    chk("midrst.dstlo", 32'(word_IP_DST_LO), 32'd0);
    chk("midrst.pay",   32'(word_PAYLOAD),   32'd0);
    chk("midrst.cnt",   32'(word_cnt),       32'd0);
    chk("midrst.ipv4",  32'(is_ipv4),        32'd0);
    drive(1'b1, 1'b1, 1'b1, beat1());
    chk("midrst.b1",    32'(word_IP_DST_LO), 32'd1);
    chk("midrst.cnt1",  32'(word_cnt),       32'd1);
    chk("midrst.ipv4b", 32'(is_ipv4),        32'd1);

    // 70000-beat packet: counter saturates at 65535
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 1'b1, (i == 69999) ? 1'b1 : 1'b0, '0);
      if (i == 1000)  chk("sat.cnt1000",  32'(word_cnt), 32'd1000);
      if (i == 65534) chk("sat.cnt65534", 32'(word_cnt), 32'd65534);
      if (i == 65535) chk("sat.cnt65535", 32'(word_cnt), 32'd65535);
      if (i == 65536) chk("sat.hold",     32'(word_cnt), 32'd65535);
      if (i == 69999) begin
        chk("sat.pay",  32'(word_PAYLOAD), 32'd1);
        chk("sat.done", 32'(pkt_done),     32'd1);
        chk("sat.runt", 32'(runt_pkt),     32'd0);
        chk("sat.last", 32'(word_cnt),     32'd65535);
      end
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("sat.clear", 32'(word_cnt), 32'd0);
    drive(1'b1, 1'b1, 1'b1, beat0(16'h0800, 8'h45));
    chk("sat.nextmac", 32'(word_MAC_HDR), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
